cmd_release_ctrl: RTL and testbench

- Multi-channel successor to the 2-bit set/clear/toggle command FSM.
- Decodes a 2-bit opcode plus a channel index, requires the code to be stable for a programmable number of cycles, then applies the action to one bit of an NCH-wide output register when the input is released (returns to opcode 00).
- Sits between the synchronised button/switch front end and the LED/enable register bank.

---
 rtl/cmd_release_pkg.sv | 19 +
 rtl/cmd_release_ctrl_hold_counter.sv | 36 +++
 rtl/cmd_release_ctrl.sv | 163 ++++++++++++++++
 tb/tb_cmd_release_ctrl.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/cmd_release_pkg.sv
// Shared opcodes, state encoding and counter width for cmd_release_ctrl.
// Optional acknowledge outputs: define CMD_RELEASE_CTRL_ACK_EN.
package cmd_release_pkg;

    localparam logic [1:0] OP_IDLE = 2'b00;
    localparam logic [1:0] OP_CLR  = 2'b01;
    localparam logic [1:0] OP_TGL  = 2'b10;
    localparam logic [1:0] OP_SET  = 2'b11;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_ARMED = 2'd2,
        ST_FIRE  = 2'd3
    } state_t;

endpackage

// File: rtl/cmd_release_ctrl_hold_counter.sv
// Saturating stability counter; reached flags that one more
// matching sample will hit the target.
module hold_counter
    import cmd_release_pkg::*;
#(
    parameter int CNT_W_P = CNT_W,
    parameter int TARGET  = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    input  logic load,
    input  logic inc,
    output logic reached
);

    localparam logic [CNT_W_P-1:0] TGT = CNT_W_P'(TARGET);
    localparam logic [CNT_W_P-1:0] ONE = CNT_W_P'(1);

    logic [CNT_W_P-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= ONE;
        end else if (inc && cnt != TGT) begin
            cnt <= cnt + ONE;
        end
    end

    assign reached = (cnt + ONE) == TGT;

endmodule

// File: rtl/cmd_release_ctrl.sv
// Multi-channel release-triggered set/clear/toggle command controller.
// Optional acknowledge outputs: define CMD_RELEASE_CTRL_ACK_EN.
module cmd_release_ctrl
    import cmd_release_pkg::*;
#(
    parameter int              NCH        = 4,
    parameter int              IDX_W      = 2,
    parameter int              STABLE_CYC = 1,
    parameter logic [NCH-1:0]  RESET_VAL  = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       ain,
    input  logic [IDX_W-1:0] ch_idx,
    output logic [NCH-1:0]   yout,
    output logic             busy
`ifdef CMD_RELEASE_CTRL_ACK_EN
    ,
    output logic             ack,
    output logic [1:0]       ack_op,
    output logic [IDX_W-1:0] ack_idx
`endif
);

    // A single-sample requirement arms directly on capture.
    localparam state_t CAP_ST =
        (STABLE_CYC == 1) ? ST_ARMED : ST_COUNT;

    state_t           state;
    logic [1:0]       cap_op;
    logic [IDX_W-1:0] cap_idx;

    logic             is_zero;
    logic             same;
    logic             c_clr;
    logic             c_load;
    logic             c_inc;
    logic             reached;
    logic [NCH-1:0]   sel;
    logic [NCH-1:0]   next_y;

    assign is_zero = (ain == OP_IDLE);
    assign same    = (ain == cap_op) && (ch_idx == cap_idx);

    hold_counter #(
        .CNT_W_P (CNT_W),
        .TARGET  (STABLE_CYC)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (c_clr),
        .load    (c_load),
        .inc     (c_inc),
        .reached (reached)
    );

    always_comb begin
        c_clr  = 1'b0;
        c_load = 1'b0;
        c_inc  = 1'b0;
        unique case (state)
            ST_IDLE, ST_FIRE: begin
                if (is_zero) c_clr  = 1'b1;
                else         c_load = 1'b1;
            end
            ST_COUNT, ST_ARMED: begin
                if (is_zero)   c_clr  = 1'b1;
                else if (same) c_inc  = 1'b1;
                else           c_load = 1'b1;
            end
            default: c_clr = 1'b1;
        endcase
    end

    // Out-of-range indices select no bit, so yout stays put.
    always_comb begin
        sel = '0;
        for (int i = 0; i < NCH; i++) begin
            sel[i] = (int'(cap_idx) == i);
        end
    end

    always_comb begin
        next_y = yout;
        unique case (cap_op)
            OP_SET:  next_y = yout | sel;
            OP_CLR:  next_y = yout & ~sel;
            OP_TGL:  next_y = yout ^ sel;
            default: next_y = yout;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            yout    <= RESET_VAL;
            cap_op  <= OP_IDLE;
            cap_idx <= '0;
            busy    <= 1'b0;
`ifdef CMD_RELEASE_CTRL_ACK_EN
            ack     <= 1'b0;
            ack_op  <= OP_IDLE;
            ack_idx <= '0;
`endif
        end else begin
`ifdef CMD_RELEASE_CTRL_ACK_EN
            ack <= 1'b0;
`endif
            unique case (state)
                ST_IDLE: begin
                    if (!is_zero) begin
                        cap_op  <= ain;
                        cap_idx <= ch_idx;
                        state   <= CAP_ST;
                        busy    <= 1'b1;
                    end
                end
                ST_COUNT: begin
                    if (is_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else if (same) begin
                        if (reached) state <= ST_ARMED;
                    end else begin
                        cap_op  <= ain;
                        cap_idx <= ch_idx;
                        state   <= CAP_ST;
                    end
                end
                ST_ARMED: begin
                    if (is_zero) begin
                        state <= ST_FIRE;
                        yout  <= next_y;
`ifdef CMD_RELEASE_CTRL_ACK_EN
                        ack     <= 1'b1;
                        ack_op  <= cap_op;
                        ack_idx <= cap_idx;
`endif
                    end else if (!same) begin
                        cap_op  <= ain;
                        cap_idx <= ch_idx;
                        state   <= CAP_ST;
                    end
                end
                ST_FIRE: begin
                    if (is_zero) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        cap_op  <= ain;
                        cap_idx <= ch_idx;
                        state   <= CAP_ST;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_release_ctrl.sv
// Bench for cmd_release_ctrl: two configurations against a run-length model.
// Acknowledge checks are active when CMD_RELEASE_CTRL_ACK_EN is defined.
module tb_cmd_release_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [1:0] ain;
    logic [1:0] ch_idx;
    logic [3:0] ya;
    logic [2:0] yb;
    logic       ba;
    logic       bb;
`ifdef CMD_RELEASE_CTRL_ACK_EN
    logic       acka, ackb;
    logic [1:0] aopa, aopb, aidxa, aidxb;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cmd_release_ctrl #(
        .NCH(4), .IDX_W(2), .STABLE_CYC(1), .RESET_VAL(4'b1010)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .ain(ain), .ch_idx(ch_idx),
        .yout(ya), .busy(ba)
`ifdef CMD_RELEASE_CTRL_ACK_EN
        , .ack(acka), .ack_op(aopa), .ack_idx(aidxa)
`endif
    );

    cmd_release_ctrl #(
        .NCH(3), .IDX_W(2), .STABLE_CYC(3), .RESET_VAL(3'b101)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .ain(ain), .ch_idx(ch_idx),
        .yout(yb), .busy(bb)
`ifdef CMD_RELEASE_CTRL_ACK_EN
        , .ack(ackb), .ack_op(aopb), .ack_idx(aidxb)
`endif
    );

    // Model: a command fires when a 00 sample ends a run of at least
    // STABLE identical nonzero {op,idx} samples.
    int         stab [2] = '{1, 3};
    int         nch  [2] = '{4, 3};
    logic [3:0] rv   [2] = '{4'b1010, 4'b0101};
    logic [3:0] m_y  [2];
    logic       m_busy [2];
    logic       m_ack  [2];
    logic [1:0] m_aop  [2];
    logic [1:0] m_aidx [2];
    logic [3:0] r_code [2];
    int         r_len  [2];

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_y[d]    = rv[d];
            m_busy[d] = 1'b0;
            m_ack[d]  = 1'b0;
            m_aop[d]  = 2'b00;
            m_aidx[d] = 2'b00;
            r_code[d] = 4'h0;
            r_len[d]  = 0;
        end
    endtask

    task automatic model_step(input int d, input logic [1:0] a,
                              input logic [1:0] i);
        logic fired;
        logic [1:0] op;
        int idx;
        fired = 1'b0;
        if (a == 2'b00) begin
            if (r_len[d] > 0 && r_len[d] >= stab[d]) begin
                fired = 1'b1;
                op  = r_code[d][3:2];
                idx = int'(r_code[d][1:0]);
                if (idx < nch[d]) begin
                    if (op == 2'b11) m_y[d][idx] = 1'b1;
                    else if (op == 2'b01) m_y[d][idx] = 1'b0;
                    else m_y[d][idx] = ~m_y[d][idx];
                end
                m_aop[d]  = op;
                m_aidx[d] = r_code[d][1:0];
            end
            r_len[d] = 0;
        end else if ({a, i} == r_code[d] && r_len[d] > 0) begin
            if (r_len[d] < 1000) r_len[d]++;
        end else begin
            r_code[d] = {a, i};
            r_len[d]  = 1;
        end
        m_busy[d] = (a != 2'b00) || fired;
        m_ack[d]  = fired;
    endtask

    task automatic check_all(input string tag);
        check({tag, "/ya"}, 32'(ya), 32'(m_y[0]));
        check({tag, "/yb"}, 32'(yb), 32'(m_y[1][2:0]));
        check({tag, "/ba"}, 32'(ba), 32'(m_busy[0]));
        check({tag, "/bb"}, 32'(bb), 32'(m_busy[1]));
`ifdef CMD_RELEASE_CTRL_ACK_EN
        check({tag, "/acka"}, 32'(acka), 32'(m_ack[0]));
        check({tag, "/ackb"}, 32'(ackb), 32'(m_ack[1]));
        check({tag, "/aopa"}, 32'(aopa), 32'(m_aop[0]));
        check({tag, "/aopb"}, 32'(aopb), 32'(m_aop[1]));
        check({tag, "/aidxa"}, 32'(aidxa), 32'(m_aidx[0]));
        check({tag, "/aidxb"}, 32'(aidxb), 32'(m_aidx[1]));
`endif
    endtask

    task automatic step(input string tag, input logic [1:0] a,
                        input logic [1:0] i);
        @(negedge clk);
        ain    = a;
        ch_idx = i;
        @(posedge clk);
        model_step(0, a, i);
        model_step(1, a, i);
        #1;
        check_all(tag);
    endtask

    task automatic hold(input string tag, input logic [1:0] a,
                        input logic [1:0] i, input int n);
        for (int k = 0; k < n; k++) step(tag, a, i);
    endtask

    task automatic mid_reset(input string tag);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        @(negedge clk);
        ain     = 2'b00;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [1:0] op;
        logic [1:0] ix;
        int len;
        reset_n = 1'b0;
        ain     = 2'b00;
        ch_idx  = 2'b00;
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk);
        reset_n = 1'b1;
        hold("idle", 2'b00, 2'b00, 5);

        step("set_cap", 2'b11, 2'd2);
        step("set_rel", 2'b00, 2'd0);
        step("set_idle", 2'b00, 2'd0);

        for (int r = 0; r < 2; r++) begin
            hold("tgl_hold", 2'b10, 2'd0, 6);
            hold("tgl_rel", 2'b00, 2'd0, 2);
        end

        hold("deb_short", 2'b11, 2'd1, 2);
        hold("deb_abort", 2'b00, 2'd0, 2);
        hold("deb_full", 2'b11, 2'd1, 3);
        hold("deb_rel", 2'b00, 2'd0, 2);

        hold("chg_set", 2'b11, 2'd3, 3);
        hold("chg_clr", 2'b01, 2'd3, 3);
        hold("chg_rel", 2'b00, 2'd0, 2);

        hold("rst_arm", 2'b10, 2'd1, 4);
        mid_reset("rst_mid");
        hold("rst_after", 2'b00, 2'd0, 2);

        step("b2b_a", 2'b10, 2'd2);
        step("b2b_r", 2'b00, 2'd0);
        step("b2b_b", 2'b10, 2'd2);
        step("b2b_r2", 2'b00, 2'd0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 39) == 0) begin
                mid_reset("rnd_rst");
            end
            op  = 2'($urandom_range(0, 3));
            ix  = 2'($urandom_range(0, 3));
            len = $urandom_range(1, 5);
            if ($urandom_range(0, 2) == 0) op = 2'b00;
            hold("rnd", op, ix, len);
        end
        hold("final", 2'b00, 2'd0, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
